tcam_reg_arb: RTL and testbench

TCAM_REG_ARB -- requirements
Module: tcam_reg_arb

---
 rtl/tcam_arb_pkg.sv | 13 +
 rtl/tcam_rr_arbiter.sv | 34 +++
 rtl/tcam_reg_arb.sv | 142 ++++++++++++++
 tb/tb_tcam_reg_arb.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_arb_pkg.sv
// Shared types and constants for the TCAM register-access arbiter.
// Holds the arbiter FSM encoding and the default requester count.
package tcam_arb_pkg;

   localparam int NumReqDef = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

endpackage

// File: rtl/tcam_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping at NumReq, returned both one-hot and as an index.
module tcam_rr_arbiter #(
   parameter int NumReq = 4,
   localparam int IdxW = $clog2(NumReq)
) (
   input  logic [NumReq-1:0] req_i,
   input  logic [IdxW-1:0]   ptr_i,
   output logic [NumReq-1:0] gnt_o,
   output logic [IdxW-1:0]   idx_o,
   output logic              valid_o
);

   int  j;
   logic found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < NumReq; i++) begin
         j = (int'(ptr_i) + i) % NumReq;
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IdxW'(j);
         end
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/tcam_reg_arb.sv
// Arbitrates NumReq register requesters onto a single TCAM register port:
// grant, one-cycle TCAM access, then a held response until accepted.
module tcam_reg_arb
   import tcam_arb_pkg::*;
#(
   parameter int NumReq = NumReqDef,
   parameter int RegAw  = 8,
   parameter int RegDw  = 32,
   localparam int RegBw = RegDw / 8,
   localparam int IdxW  = $clog2(NumReq)
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NumReq-1:0]            req_i,
   input  logic [NumReq-1:0]            we_i,
   input  logic [NumReq-1:0][RegAw-1:0] addr_i,
   input  logic [NumReq-1:0][RegDw-1:0] wdata_i,
   input  logic [NumReq-1:0][RegBw-1:0] be_i,
   output logic [NumReq-1:0]            gnt_o,
   output logic [NumReq-1:0]            rvalid_o,
   input  logic [NumReq-1:0]            rready_i,
   output logic [RegDw-1:0]             rdata_o,
   output logic                         rerr_o,
   output logic                         tcam_req_o,
   output logic                         tcam_re_o,
   output logic                         tcam_we_o,
   output logic [RegAw-1:0]             tcam_addr_o,
   output logic [RegDw-1:0]             tcam_wdata_o,
   output logic [RegBw-1:0]             tcam_be_o,
   input  logic [RegDw-1:0]             tcam_rdata_i,
   input  logic                         tcam_error_i
);

   state_e            state_q, state_d;
   logic [IdxW-1:0]   ptr_q, ptr_d;
   logic [IdxW-1:0]   k_q, k_d;
   logic              we_q, we_d;
   logic [RegAw-1:0]  addr_q, addr_d;
   logic [RegDw-1:0]  wdata_q, wdata_d;
   logic [RegBw-1:0]  be_q, be_d;
   logic [RegDw-1:0]  rdata_q, rdata_d;
   logic              rerr_q, rerr_d;

   logic [NumReq-1:0] win_gnt;
   logic [IdxW-1:0]   win_idx;
   logic              win_vld;
   logic              misalign;

   tcam_rr_arbiter #(
      .NumReq (NumReq)
   ) u_rr (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .gnt_o   (win_gnt),
      .idx_o   (win_idx),
      .valid_o (win_vld)
   );

   assign misalign = we_q & (|addr_q[1:0]);

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      k_d          = k_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      rdata_d      = rdata_q;
      rerr_d       = rerr_q;
      gnt_o        = '0;
      rvalid_o     = '0;
      rdata_o      = '0;
      rerr_o       = 1'b0;
      tcam_req_o   = 1'b0;
      tcam_re_o    = 1'b0;
      tcam_we_o    = 1'b0;
      tcam_addr_o  = '0;
      tcam_wdata_o = '0;
      tcam_be_o    = '0;
      unique case (state_q)
         IDLE: begin
            // Grant is combinational, so mask it while reset holds the FSM.
            if (win_vld && !rst_i) begin
               gnt_o   = win_gnt;
               k_d     = win_idx;
               we_d    = we_i[win_idx];
               addr_d  = addr_i[win_idx];
               wdata_d = wdata_i[win_idx];
               be_d    = be_i[win_idx];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            tcam_req_o   = 1'b1;
            tcam_we_o    = we_q & ~misalign;
            tcam_re_o    = ~we_q;
            tcam_addr_o  = {addr_q[RegAw-1:2], 2'b00};
            tcam_wdata_o = wdata_q;
            tcam_be_o    = be_q;
            rdata_d      = we_q ? '0 : tcam_rdata_i;
            rerr_d       = tcam_error_i | misalign;
            state_d      = RESP;
         end
         RESP: begin
            rvalid_o[k_q] = 1'b1;
            rdata_o       = rdata_q;
            rerr_o        = rerr_q;
            if (rready_i[k_q]) begin
               ptr_d   = (int'(k_q) == NumReq - 1) ? '0 : k_q + 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         k_q     <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         k_q     <= k_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         rerr_q  <= rerr_d;
      end
   end

endmodule

// File: tb/tb_tcam_reg_arb.sv
// Directed bench for tcam_reg_arb: four requesters, 8-bit address,
// 32-bit data; inputs change 1ns after the rising edge, checks 1ns later.
module tb_tcam_reg_arb;

   logic             clk;
   logic             rst;
   logic [3:0]       req;
   logic [3:0]       we;
   logic [3:0][7:0]  addr;
   logic [3:0][31:0] wdata;
   logic [3:0][3:0]  be;
   logic [3:0]       gnt;
   logic [3:0]       rvalid;
   logic [3:0]       rready;
   logic [31:0]      rdata;
   logic             rerr;
   logic             t_req;
   logic             t_re;
   logic             t_we;
   logic [7:0]       t_addr;
   logic [31:0]      t_wdata;
   logic [3:0]       t_be;
   logic [31:0]      t_rdata;
   logic             t_err;

   int errors;
   int checks;

   tcam_reg_arb #(
      .NumReq (4),
      .RegAw  (8),
      .RegDw  (32)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_i        (req),
      .we_i         (we),
      .addr_i       (addr),
      .wdata_i      (wdata),
      .be_i         (be),
      .gnt_o        (gnt),
      .rvalid_o     (rvalid),
      .rready_i     (rready),
      .rdata_o      (rdata),
      .rerr_o       (rerr),
      .tcam_req_o   (t_req),
      .tcam_re_o    (t_re),
      .tcam_we_o    (t_we),
      .tcam_addr_o  (t_addr),
      .tcam_wdata_o (t_wdata),
      .tcam_be_o    (t_be),
      .tcam_rdata_i (t_rdata),
      .tcam_error_i (t_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      req    = 4'hF;
      we     = 4'h0;
      rready = 4'h0;
      t_rdata = 32'h0;
      t_err  = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'h0) begin
         errors++;
         $display("FAIL rst_gnt: got %h want 0", gnt);
      end
      checks++;
      if ({rvalid, t_req, t_re, t_we, t_addr, t_be} !== 19'h0) begin
         errors++;
         $display("FAIL rst_outs: rvalid=%h req=%b addr=%h want 0",
                  rvalid, t_req, t_addr);
      end
      checks++;
      if ({rdata, rerr, t_wdata} !== 65'h0) begin
         errors++;
         $display("FAIL rst_data: rdata=%h rerr=%b want 0", rdata, rerr);
      end
      req = 4'h0;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      cyc();
      req[0]  = 1'b1;
      we[0]   = 1'b0;
      addr[0] = 8'h14;
      #1;
      checks++;
      if (gnt !== 4'b0001 || t_req !== 1'b0) begin
         errors++;
         $display("FAIL rd_gnt: gnt=%h treq=%b want 1/0", gnt, t_req);
      end
      cyc();
      req     = 4'h0;
      t_rdata = 32'hDEADBEEF;
      #1;
      checks++;
      if ({t_req, t_re, t_we, t_addr} !== {3'b110, 8'h14} || gnt !== 4'h0) begin
         errors++;
         $display("FAIL rd_issue: req=%b re=%b we=%b addr=%h gnt=%h",
                  t_req, t_re, t_we, t_addr, gnt);
      end
      cyc();
      t_rdata   = 32'h0;
      rready[0] = 1'b1;
      #1;
      checks++;
      if (rvalid !== 4'b0001 || rdata !== 32'hDEADBEEF || rerr !== 1'b0) begin
         errors++;
         $display("FAIL rd_resp: rvalid=%h rdata=%h rerr=%b want 1/deadbeef/0",
                  rvalid, rdata, rerr);
      end
      checks++;
      if (t_req !== 1'b0) begin
         errors++;
         $display("FAIL rd_strobe_off: got %b want 0", t_req);
      end
      cyc();
      rready = 4'h0;
      #1;
      checks++;
      if (rvalid !== 4'h0 || gnt !== 4'h0) begin
         errors++;
         $display("FAIL rd_done: rvalid=%h gnt=%h want 0", rvalid, gnt);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      cyc();
      req    = 4'hF;
      we     = 4'h0;
      rready = 4'hF;
      for (int i = 0; i < 4; i++) addr[i] = 8'(i * 4);
      for (int n = 0; n < 5; n++) begin
         #1;
         checks++;
         if (gnt !== exp_g[n]) begin
            errors++;
            $display("FAIL rr_gnt%0d: got %h want %h", n, gnt, exp_g[n]);
         end
         cyc();
         t_rdata = 32'h100 + 32'(n);
         cyc();
         #1;
         checks++;
         if (rvalid !== exp_g[n] || rdata !== 32'h100 + 32'(n)) begin
            errors++;
            $display("FAIL rr_resp%0d: rvalid=%h rdata=%h want %h/%h",
                     n, rvalid, rdata, exp_g[n], 32'h100 + 32'(n));
         end
         cyc();
      end
      req    = 4'h0;
      rready = 4'h0;
   endtask

   task automatic test_misaligned_write();
      cyc();
      req[2]   = 1'b1;
      we[2]    = 1'b1;
      addr[2]  = 8'h13;
      wdata[2] = 32'hCAFEF00D;
      be[2]    = 4'hF;
      #1;
      checks++;
      if (gnt !== 4'b0100) begin
         errors++;
         $display("FAIL mis_gnt: got %h want 4", gnt);
      end
      cyc();
      req     = 4'h0;
      t_rdata = 32'h12345678;
      #1;
      checks++;
      if ({t_req, t_we, t_re, t_addr} !== {3'b100, 8'h10}) begin
         errors++;
         $display("FAIL mis_issue: req=%b we=%b re=%b addr=%h want 1/0/0/10",
                  t_req, t_we, t_re, t_addr);
      end
      cyc();
      rready[2] = 1'b1;
      #1;
      checks++;
      if (rvalid !== 4'b0100 || rerr !== 1'b1 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL mis_resp: rvalid=%h rerr=%b rdata=%h want 4/1/0",
                  rvalid, rerr, rdata);
      end
      cyc();
      rready = 4'h0;
      we     = 4'h0;
   endtask

   task automatic test_aligned_write();
      cyc();
      req[3]   = 1'b1;
      we[3]    = 1'b1;
      addr[3]  = 8'h20;
      wdata[3] = 32'h5A5A1234;
      be[3]    = 4'h5;
      #1;
      checks++;
      if (gnt !== 4'b1000) begin
         errors++;
         $display("FAIL wr_gnt: got %h want 8", gnt);
      end
      cyc();
      req     = 4'h0;
      t_rdata = 32'hFFFFFFFF;
      #1;
      checks++;
      if ({t_req, t_we, t_re, t_addr, t_wdata, t_be}
          !== {3'b110, 8'h20, 32'h5A5A1234, 4'h5}) begin
         errors++;
         $display("FAIL wr_issue: we=%b re=%b addr=%h wdata=%h be=%h",
                  t_we, t_re, t_addr, t_wdata, t_be);
      end
      cyc();
      rready[3] = 1'b1;
      #1;
      checks++;
      if (rvalid !== 4'b1000 || rerr !== 1'b0 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL wr_resp: rvalid=%h rerr=%b rdata=%h want 8/0/0",
                  rvalid, rerr, rdata);
      end
      cyc();
      rready = 4'h0;
      we     = 4'h0;
   endtask

   task automatic test_backpressure();
      cyc();
      req[1]  = 1'b1;
      addr[1] = 8'h08;
      #1;
      checks++;
      if (gnt !== 4'b0010) begin
         errors++;
         $display("FAIL bp_gnt: got %h want 2", gnt);
      end
      cyc();
      t_rdata = 32'hA5A50001;
      req     = 4'hF;
      rready  = 4'b1101;
      cyc();
      t_rdata = 32'h0;
      for (int n = 0; n < 5; n++) begin
         #1;
         checks++;
         if (rvalid !== 4'b0010 || rdata !== 32'hA5A50001 || gnt !== 4'h0) begin
            errors++;
            $display("FAIL bp_hold%0d: rvalid=%h rdata=%h gnt=%h", n,
                     rvalid, rdata, gnt);
         end
         cyc();
      end
      rready = 4'hF;
      cyc();
      #1;
      checks++;
      if (gnt !== 4'b0100 || rvalid !== 4'h0) begin
         errors++;
         $display("FAIL bp_next_gnt: gnt=%h rvalid=%h want 4/0", gnt, rvalid);
      end
      req = 4'h0;
      cyc();
      cyc();
      cyc();
      rready = 4'h0;
   endtask

   task automatic test_idle_no_req();
      req = 4'h0;
      #1;
      checks++;
      if (gnt !== 4'h0 || t_req !== 1'b0 || rvalid !== 4'h0) begin
         errors++;
         $display("FAIL idle: gnt=%h treq=%b rvalid=%h want 0", gnt, t_req, rvalid);
      end
      cyc();
      #1;
      checks++;
      if (t_req !== 1'b0) begin
         errors++;
         $display("FAIL idle_stay: treq=%b want 0", t_req);
      end
   endtask

   task automatic test_reset_in_issue();
      cyc();
      req[2]  = 1'b1;
      addr[2] = 8'h30;
      cyc();
      req = 4'h0;
      #1;
      checks++;
      if (t_req !== 1'b1 || t_addr !== 8'h30) begin
         errors++;
         $display("FAIL ri_issue: treq=%b addr=%h want 1/30", t_req, t_addr);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({t_req, t_re, t_we, t_addr, gnt, rvalid, rerr} !== 20'h0
          || rdata !== 32'h0) begin
         errors++;
         $display("FAIL ri_abort: treq=%b re=%b addr=%h rvalid=%h rdata=%h",
                  t_req, t_re, t_addr, rvalid, rdata);
      end
      cyc();
      rst     = 1'b0;
      req     = 4'b1010;
      addr[1] = 8'h04;
      addr[3] = 8'h0C;
      #1;
      checks++;
      if (gnt !== 4'b0010) begin
         errors++;
         $display("FAIL ri_ptr0: gnt=%h want 2", gnt);
      end
      cyc();
      req    = 4'h0;
      rready = 4'hF;
      cyc();
      #1;
      checks++;
      if (rvalid !== 4'b0010) begin
         errors++;
         $display("FAIL ri_resp: rvalid=%h want 2", rvalid);
      end
      cyc();
      rready = 4'h0;
   endtask

   task automatic test_read_error();
      cyc();
      req[3]  = 1'b1;
      we[3]   = 1'b0;
      addr[3] = 8'h40;
      #1;
      checks++;
      if (gnt !== 4'b1000) begin
         errors++;
         $display("FAIL er_gnt: got %h want 8", gnt);
      end
      cyc();
      req     = 4'h0;
      t_rdata = 32'h0BADF00D;
      t_err   = 1'b1;
      cyc();
      t_err     = 1'b0;
      t_rdata   = 32'h0;
      rready[3] = 1'b1;
      #1;
      checks++;
      if (rvalid !== 4'b1000 || rerr !== 1'b1 || rdata !== 32'h0BADF00D) begin
         errors++;
         $display("FAIL er_resp: rvalid=%h rerr=%b rdata=%h want 8/1/0badf00d",
                  rvalid, rerr, rdata);
      end
      cyc();
      rready = 4'h0;
      #1;
      checks++;
      if (rvalid !== 4'h0 || rerr !== 1'b0) begin
         errors++;
         $display("FAIL er_done: rvalid=%h rerr=%b want 0", rvalid, rerr);
      end
   endtask

   task automatic test_wrap();
      cyc();
      req = 4'b1001;
      #1;
      checks++;
      if (gnt !== 4'b0001) begin
         errors++;
         $display("FAIL wrap_gnt: got %h want 1", gnt);
      end
      cyc();
      req    = 4'h0;
      rready = 4'hF;
      cyc();
      cyc();
      rready = 4'h0;
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      rst     = 1'b1;
      req     = '0;
      we      = '0;
      addr    = '0;
      wdata   = '0;
      be      = '0;
      rready  = '0;
      t_rdata = '0;
      t_err   = 1'b0;
      test_reset();
      test_single_read();
      test_reset();
      test_round_robin();
      test_misaligned_write();
      test_aligned_write();
      test_backpressure();
      test_idle_no_req();
      test_reset_in_issue();
      test_read_error();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
